// File: rtl/bky_unload_fsm_if.sv
// bky_unload_fsm_if: handshake bundle between the unload sequencer, the chain tail and the readback FIFO
//   START     : readback request (level, held until UNLD_DONE)
//   SDI       : serial data from the chain tail
//   FULL      : readback FIFO full
//   SHFT_ENA  : chain shift enable
//   WRENA     : FIFO write strobe, one cycle per word
//   DOUT      : assembled 16-bit word
//   UNLD_DONE : readback complete
interface bky_unload_fsm_if;
    logic        START;
    logic        SDI;
    logic        FULL;
    logic        SHFT_ENA;
    logic        WRENA;
    logic [15:0] DOUT;
    logic        UNLD_DONE;
    modport master (output START, SDI, FULL, input SHFT_ENA, WRENA, DOUT, UNLD_DONE);
    modport slave  (input START, SDI, FULL, output SHFT_ENA, WRENA, DOUT, UNLD_DONE);
endinterface

// File: rtl/bky_unload_fsm.sv
// bky_unload_fsm: TMR readback sequencer that shifts the config chain out MSB-first into 16-bit FIFO words
//   CLK : clock, all registers update on the falling edge
//   RST : asynchronous active-high reset
//   bus : slave side of bky_unload_fsm_if (START/SDI/FULL in, SHFT_ENA/WRENA/DOUT/UNLD_DONE out)
module bky_unload_fsm #(
    parameter int NWORDS = 18,
    parameter int WIDTH  = 16
) (
    input logic             CLK,
    input logic             RST,
    bky_unload_fsm_if.slave bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SHIFT     = 3'd1;
    localparam logic [2:0] WAIT4ROOM = 3'd2;
    localparam logic [2:0] WRITE     = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;
    logic [2:0]       st_v;
    logic [3:0]       scnt_v;
    logic [4:0]       loop_v;
    logic [WIDTH-2:0] sr_v;
    logic [WIDTH-1:0] dout_v;
    logic             shft_v;
    logic             wr_v;
    logic             done_v;
    // Each copy derives its next value from the voted state, so an upset copy is rewritten on the next edge.
    for (genvar i = 0; i < 3; i++) begin : g_tmr
        logic [2:0]       st_q, st_n;
        logic [3:0]       scnt_q, scnt_n;
        logic [4:0]       loop_q, loop_n;
        logic [WIDTH-2:0] sr_q, sr_n;
        logic [WIDTH-1:0] dout_q, dout_n;
        logic             shft_q, wr_q, done_q;
        always_comb begin
            st_n   = st_v;
            scnt_n = scnt_v;
            loop_n = loop_v;
            sr_n   = sr_v;
            dout_n = dout_v;
            case (st_v)
                IDLE: begin
                    st_n   = bus.START ? SHIFT : IDLE;
                    scnt_n = bus.START ? 4'd0 : scnt_v;
                    loop_n = bus.START ? 5'd0 : loop_v;
                end
                SHIFT: begin
                    sr_n   = {sr_v[WIDTH-3:0], bus.SDI};
                    scnt_n = scnt_v + 4'd1;
                    if (scnt_v == 4'd15) begin
                        st_n   = bus.FULL ? WAIT4ROOM : WRITE;
                        dout_n = {sr_v, bus.SDI};
                    end
                end
                WAIT4ROOM: st_n = bus.FULL ? WAIT4ROOM : WRITE;
                WRITE: begin
                    st_n   = (loop_v == 5'(NWORDS - 1)) ? DONE : SHIFT;
                    loop_n = (loop_v == 5'(NWORDS - 1)) ? loop_v : loop_v + 5'd1;
                end
                DONE: st_n = bus.START ? DONE : IDLE;
                default: st_n = IDLE;
            endcase
        end
        // Flags are registered from the next state so they cover the whole cycle of that state.
        always_ff @(negedge CLK or posedge RST) begin
            if (RST) begin
                st_q   <= IDLE;
                scnt_q <= '0;
                loop_q <= '0;
                sr_q   <= '0;
                dout_q <= '0;
                shft_q <= 1'b0;
                wr_q   <= 1'b0;
                done_q <= 1'b0;
            end else begin
                st_q   <= st_n;
                scnt_q <= scnt_n;
                loop_q <= loop_n;
                sr_q   <= sr_n;
                dout_q <= dout_n;
                shft_q <= (st_n == SHIFT);
                wr_q   <= (st_n == WRITE);
                done_q <= (st_n == DONE);
            end
        end
    end
    always_comb begin
        st_v   = (g_tmr[0].st_q & g_tmr[1].st_q) | (g_tmr[0].st_q & g_tmr[2].st_q) | (g_tmr[1].st_q & g_tmr[2].st_q);
        scnt_v = (g_tmr[0].scnt_q & g_tmr[1].scnt_q) | (g_tmr[0].scnt_q & g_tmr[2].scnt_q) | (g_tmr[1].scnt_q & g_tmr[2].scnt_q);
        loop_v = (g_tmr[0].loop_q & g_tmr[1].loop_q) | (g_tmr[0].loop_q & g_tmr[2].loop_q) | (g_tmr[1].loop_q & g_tmr[2].loop_q);
        sr_v   = (g_tmr[0].sr_q & g_tmr[1].sr_q) | (g_tmr[0].sr_q & g_tmr[2].sr_q) | (g_tmr[1].sr_q & g_tmr[2].sr_q);
        dout_v = (g_tmr[0].dout_q & g_tmr[1].dout_q) | (g_tmr[0].dout_q & g_tmr[2].dout_q) | (g_tmr[1].dout_q & g_tmr[2].dout_q);
        shft_v = (g_tmr[0].shft_q & g_tmr[1].shft_q) | (g_tmr[0].shft_q & g_tmr[2].shft_q) | (g_tmr[1].shft_q & g_tmr[2].shft_q);
        wr_v   = (g_tmr[0].wr_q & g_tmr[1].wr_q) | (g_tmr[0].wr_q & g_tmr[2].wr_q) | (g_tmr[1].wr_q & g_tmr[2].wr_q);
        done_v = (g_tmr[0].done_q & g_tmr[1].done_q) | (g_tmr[0].done_q & g_tmr[2].done_q) | (g_tmr[1].done_q & g_tmr[2].done_q);
    end
    assign bus.SHFT_ENA  = shft_v;
    assign bus.WRENA     = wr_v;
    assign bus.DOUT      = dout_v;
    assign bus.UNLD_DONE = done_v;
endmodule
